vga_object_layer: RTL and testbench

VGA_OBJECT_LAYER -- requirements
Module: vga_object_layer

---
 rtl/vga_pkg.sv | 6 +
 rtl/obj_hit.sv | 19 +
 rtl/vga_object_layer.sv | 130 +++++++++++++
 tb/tb_vga_object_layer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared object colours and the screen coordinate type for the VGA overlay stages.
package vga_pkg;
    typedef logic [10:0] coord_t;
    localparam logic [11:0] BALL_RGB = 12'hfff;
    localparam logic [3:0][11:0] PAD_RGB = {12'hff0, 12'h00f, 12'h0f0, 12'hf00};
endpackage

// File: rtl/obj_hit.sv
// obj_hit: combinational rectangle hit test, inclusive top-left and exclusive bottom-right.
module obj_hit
    import vga_pkg::*;
(
    input  coord_t i_x,
    input  coord_t i_y,
    input  coord_t i_w,
    input  coord_t i_h,
    input  coord_t i_hcount,
    input  coord_t i_vcount,
    output logic   o_hit
);
    // 12-bit far edges so objects near 2047 clip instead of wrapping to 0
    logic [11:0] w_x_end, w_y_end;
    assign w_x_end = {1'b0, i_x} + {1'b0, i_w};
    assign w_y_end = {1'b0, i_y} + {1'b0, i_h};
    assign o_hit = (i_hcount >= i_x) && ({1'b0, i_hcount} < w_x_end) &&
                   (i_vcount >= i_y) && ({1'b0, i_vcount} < w_y_end);
endmodule

// File: rtl/vga_object_layer.sv
// vga_object_layer: draws a ball and up to four paddles over a VGA stream, 2-cycle latency,
// object positions latched once per frame at the rising edge of vsync.
module vga_object_layer
    import vga_pkg::*;
#(
    parameter int N_PADS     = 2,
    parameter int PAD_W      = 10,
    parameter int PAD_H      = 80,
    parameter int BALL_SZ    = 10,
    parameter int BLINK_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [10:0]            vcount_in,
    input  logic [10:0]            hcount_in,
    input  logic                   vsync_in,
    input  logic                   hsync_in,
    input  logic                   vblnk_in,
    input  logic                   hblnk_in,
    input  logic [11:0]            rgb_in,
    input  logic [N_PADS-1:0][10:0] pad_x,
    input  logic [N_PADS-1:0][10:0] pad_y,
    input  logic [10:0]            ball_x,
    input  logic [10:0]            ball_y,
    input  logic                   ball_blink,
    output logic [10:0]            vcount_out,
    output logic [10:0]            hcount_out,
    output logic                   vsync_out,
    output logic                   hsync_out,
    output logic                   vblnk_out,
    output logic                   hblnk_out,
    output logic [11:0]            rgb_out
);
    if (N_PADS < 1 || N_PADS > 4 || PAD_W < 1 || PAD_H < 1 || BALL_SZ < 1 || BLINK_LOG2 < 0) begin : g_bad_params
        $error("vga_object_layer: illegal parameter value");
    end

    logic                    r_vs_prev, r_valid, r_blink;
    logic [BLINK_LOG2:0]     r_frame;
    logic [N_PADS-1:0][10:0] r_pad_x, r_pad_y;
    coord_t                  r_ball_x, r_ball_y;
    logic                    w_strobe, w_ball_raw;
    logic [N_PADS:0]         w_hit, r_hit;
    logic [10:0]             r1_vcount, r1_hcount;
    logic                    r1_vs, r1_hs, r1_vb, r1_hb;
    logic [11:0]             r1_rgb, w_rgb;
    logic [N_PADS:0][11:0]   w_chain;

    assign w_strobe = vsync_in & ~r_vs_prev;

    // bit 0 is the ball, bit i+1 is paddle i
    obj_hit u_ball (
        .i_x(r_ball_x), .i_y(r_ball_y), .i_w(coord_t'(BALL_SZ)), .i_h(coord_t'(BALL_SZ)),
        .i_hcount(hcount_in), .i_vcount(vcount_in), .o_hit(w_ball_raw)
    );
    assign w_hit[0] = w_ball_raw & ~(r_blink & r_frame[BLINK_LOG2]);

    for (genvar i = 0; i < N_PADS; i++) begin : g_pad
        obj_hit u_pad (
            .i_x(r_pad_x[i]), .i_y(r_pad_y[i]), .i_w(coord_t'(PAD_W)), .i_h(coord_t'(PAD_H)),
            .i_hcount(hcount_in), .i_vcount(vcount_in), .o_hit(w_hit[i+1])
        );
        assign w_chain[i] = r_hit[i+1] ? PAD_RGB[i] : w_chain[i+1];
    end
    assign w_chain[N_PADS] = r1_rgb;

    always_comb begin
        w_rgb = (r1_vb | r1_hb) ? r1_rgb : r_hit[0] ? BALL_RGB : w_chain[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_prev <= 1'b0;
            r_valid   <= 1'b0;
            r_blink   <= 1'b0;
            r_frame   <= '0;
            r_pad_x   <= '0;
            r_pad_y   <= '0;
            r_ball_x  <= '0;
            r_ball_y  <= '0;
        end else begin
            r_vs_prev <= vsync_in;
            if (w_strobe) begin
                r_valid  <= 1'b1;
                r_frame  <= r_frame + 1'b1;
                r_blink  <= ball_blink;
                r_pad_x  <= pad_x;
                r_pad_y  <= pad_y;
                r_ball_x <= ball_x;
                r_ball_y <= ball_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit      <= '0;
            r1_vcount  <= '0;
            r1_hcount  <= '0;
            r1_vs      <= 1'b0;
            r1_hs      <= 1'b0;
            r1_vb      <= 1'b0;
            r1_hb      <= 1'b0;
            r1_rgb     <= '0;
            vcount_out <= '0;
            hcount_out <= '0;
            vsync_out  <= 1'b0;
            hsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            r_hit      <= r_valid ? w_hit : '0;
            r1_vcount  <= vcount_in;
            r1_hcount  <= hcount_in;
            r1_vs      <= vsync_in;
            r1_hs      <= hsync_in;
            r1_vb      <= vblnk_in;
            r1_hb      <= hblnk_in;
            r1_rgb     <= rgb_in;
            vcount_out <= r1_vcount;
            hcount_out <= r1_hcount;
            vsync_out  <= r1_vs;
            hsync_out  <= r1_hs;
            vblnk_out  <= r1_vb;
            hblnk_out  <= r1_hb;
            rgb_out    <= w_rgb;
        end
    end
endmodule

// File: tb/tb_vga_object_layer.sv
// tb_vga_object_layer: table-driven pixel checks, hand-written frame sequences and a random
// stream, all compared against a frame-level reference model of the object overlay.
module tb_vga_object_layer;
    localparam int N = 2, PW = 10, PH = 80, BS = 10, BL = 4;

    logic clk = 1'b0, rst;
    logic [10:0] vcount_in, hcount_in, vcount_out, hcount_out;
    logic vsync_in, hsync_in, vblnk_in, hblnk_in, vsync_out, hsync_out, vblnk_out, hblnk_out;
    logic [11:0] rgb_in, rgb_out;
    logic [N-1:0][10:0] pad_x, pad_y;
    logic [10:0] ball_x, ball_y;
    logic ball_blink;

    int checks = 0, errors = 0, nstrobe = 0;
    logic [11:0] padc [4] = '{12'hf00, 12'h0f0, 12'h00f, 12'hff0};

    vga_object_layer #(.N_PADS(N), .PAD_W(PW), .PAD_H(PH), .BALL_SZ(BS), .BLINK_LOG2(BL)) dut (
        .clk(clk), .rst(rst),
        .vcount_in(vcount_in), .hcount_in(hcount_in), .vsync_in(vsync_in), .hsync_in(hsync_in),
        .vblnk_in(vblnk_in), .hblnk_in(hblnk_in), .rgb_in(rgb_in),
        .pad_x(pad_x), .pad_y(pad_y), .ball_x(ball_x), .ball_y(ball_y), .ball_blink(ball_blink),
        .vcount_out(vcount_out), .hcount_out(hcount_out), .vsync_out(vsync_out), .hsync_out(hsync_out),
        .vblnk_out(vblnk_out), .hblnk_out(hblnk_out), .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    // Reference model: what the overlay shows for a pixel given positions latched per frame
    bit m_valid, m_prev_vs, m_blink;
    int m_frames, m_bx, m_by;
    int m_px [N], m_py [N];

    function automatic bit in_rect(int x, int y, int w, int hh, int h, int v);
        return h >= x && h < x + w && v >= y && v < y + hh;
    endfunction

    function automatic logic [11:0] model_rgb(int h, int v, bit blank, logic [11:0] rin);
        if (!m_valid || blank) return rin;
        if (in_rect(m_bx, m_by, BS, BS, h, v) && !(m_blink && (m_frames % 32) >= 16)) return 12'hfff;
        for (int i = 0; i < N; i++)
            if (in_rect(m_px[i], m_py[i], PW, PH, h, v)) return padc[i];
        return rin;
    endfunction

    typedef struct packed {
        logic [10:0] v, h;
        logic vs, hs, vb, hb;
        logic [11:0] rgb;
    } px_t;
    px_t q[$];
    px_t cur, got, exp_px;
    bit s_rst;

    initial forever begin
        @(posedge clk);
        s_rst = rst;
        cur.v = vcount_in; cur.h = hcount_in; cur.vs = vsync_in; cur.hs = hsync_in;
        cur.vb = vblnk_in; cur.hb = hblnk_in;
        cur.rgb = model_rgb(int'(hcount_in), int'(vcount_in), vblnk_in | hblnk_in, rgb_in);
        if (s_rst) begin
            q.delete();
            q.push_back('0);
            m_valid = 0; m_prev_vs = 0; m_blink = 0; m_frames = 0; m_bx = 0; m_by = 0;
            for (int i = 0; i < N; i++) begin m_px[i] = 0; m_py[i] = 0; end
        end else begin
            q.push_back(cur);
            if (vsync_in && !m_prev_vs) begin
                m_valid = 1; m_frames++; m_blink = ball_blink;
                m_bx = int'(ball_x); m_by = int'(ball_y);
                for (int i = 0; i < N; i++) begin m_px[i] = int'(pad_x[i]); m_py[i] = int'(pad_y[i]); end
            end
            m_prev_vs = vsync_in;
        end
        #1;
        got = {vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out, rgb_out};
        if (s_rst) begin
            checks++;
            if (got !== '0) begin errors++; $display("FAIL reset_out: got %h required 0", got); end
        end else if (q.size() >= 2) begin
            exp_px = q.pop_front();
            checks++;
            if (got !== exp_px) begin
                errors++;
                $display("FAIL stream: got %h required %h at %0t", got, exp_px, $time);
            end
        end
    end

    task automatic set_px(int h, int v, bit hb, bit vb);
        hcount_in = 11'(h); vcount_in = 11'(v); hblnk_in = hb; vblnk_in = vb;
        hsync_in = hb; vsync_in = 1'b0;
    endtask

    task automatic chk_px(string name, int h, int v, bit hb, logic [11:0] ex);
        set_px(h, v, hb, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (rgb_out !== ex) begin
            errors++;
            $display("FAIL %s (h=%0d v=%0d): got %h required %h", name, h, v, rgb_out, ex);
        end
    endtask

    task automatic strobe();
        set_px(0, 0, 1'b1, 1'b1);
        vsync_in = 1'b1;
        @(negedge clk);
        vsync_in = 1'b0;
        @(negedge clk);
        nstrobe++;
    endtask

    task automatic place(int p0x, int p0y, int p1x, int p1y, int bx, int by, bit bl);
        pad_x[0] = 11'(p0x); pad_y[0] = 11'(p0y); pad_x[1] = 11'(p1x); pad_y[1] = 11'(p1y);
        ball_x = 11'(bx); ball_y = 11'(by); ball_blink = bl;
    endtask

    typedef struct {
        int setup;
        int h;
        int v;
        bit hb;
        logic [11:0] ex;
    } vec_t;
    vec_t vecs[$];

    initial begin
        rst = 1'b1; rgb_in = 12'h123;
        set_px(0, 0, 1'b0, 1'b0);
        place(0, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // latency: plain stream before any frame strobe, objects placed but not yet latched
        place(20, 100, 600, 300, 400, 300, 1'b0);
        for (int i = 0; i < 20; i++) begin set_px(15 + i, 110, 1'b0, 1'b0); @(negedge clk); end

        // setup: -1 keep, 0 edge layout without strobe, 1 edge layout + strobe, 2 overlap layout + strobe
        vecs.push_back('{0, 25, 150, 0, 12'h123});
        vecs.push_back('{1, 20, 100, 0, 12'hf00});
        vecs.push_back('{-1, 29, 179, 0, 12'hf00});
        vecs.push_back('{-1, 29, 100, 0, 12'hf00});
        vecs.push_back('{-1, 20, 179, 0, 12'hf00});
        vecs.push_back('{-1, 19, 100, 0, 12'h123});
        vecs.push_back('{-1, 30, 100, 0, 12'h123});
        vecs.push_back('{-1, 20, 99, 0, 12'h123});
        vecs.push_back('{-1, 20, 180, 0, 12'h123});
        vecs.push_back('{-1, 25, 150, 1, 12'h123});
        vecs.push_back('{-1, 400, 300, 0, 12'hfff});
        vecs.push_back('{-1, 409, 309, 0, 12'hfff});
        vecs.push_back('{-1, 410, 300, 0, 12'h123});
        vecs.push_back('{-1, 400, 310, 0, 12'h123});
        vecs.push_back('{-1, 600, 300, 0, 12'h0f0});
        vecs.push_back('{2, 27, 125, 0, 12'hfff});
        vecs.push_back('{-1, 22, 125, 0, 12'hf00});
        vecs.push_back('{-1, 27, 115, 0, 12'hf00});
        vecs.push_back('{-1, 32, 115, 0, 12'h0f0});
        vecs.push_back('{-1, 32, 125, 0, 12'hfff});
        vecs.push_back('{-1, 32, 135, 0, 12'h0f0});
        vecs.push_back('{-1, 35, 135, 0, 12'h123});
        foreach (vecs[k]) begin
            if (vecs[k].setup == 0 || vecs[k].setup == 1) place(20, 100, 600, 300, 400, 300, 1'b0);
            if (vecs[k].setup == 2) place(20, 100, 25, 110, 25, 120, 1'b0);
            if (vecs[k].setup >= 1) strobe();
            chk_px($sformatf("vec%0d", k), vecs[k].h, vecs[k].v, vecs[k].hb, vecs[k].ex);
        end

        // tearing: a mid-frame move only shows after the next strobe
        place(20, 100, 600, 300, 400, 300, 1'b0);
        strobe();
        chk_px("tear_before", 405, 300, 0, 12'hfff);
        ball_x = 11'd500;
        chk_px("tear_old_pos", 405, 301, 0, 12'hfff);
        chk_px("tear_new_early", 505, 301, 0, 12'h123);
        strobe();
        chk_px("tear_new_pos", 505, 301, 0, 12'hfff);
        chk_px("tear_old_gone", 405, 301, 0, 12'h123);

        // blink: visible for frame counts 0..15 mod 32, hidden 16..31
        place(20, 100, 600, 300, 400, 300, 1'b1);
        for (int f = 0; f < 40; f++) begin
            strobe();
            chk_px($sformatf("blink_f%0d", nstrobe), 405, 305, 0, ((nstrobe % 32) < 16) ? 12'hfff : 12'h123);
        end
        ball_blink = 1'b0;
        for (int f = 0; f < 20; f++) begin
            strobe();
            chk_px($sformatf("noblink_f%0d", nstrobe), 405, 305, 0, 12'hfff);
        end

        // clip at the right edge, never wrapping to column 0
        place(2045, 100, 600, 300, 400, 300, 1'b0);
        strobe();
        chk_px("clip_2045", 2045, 120, 0, 12'hf00);
        chk_px("clip_2047", 2047, 120, 0, 12'hf00);
        chk_px("clip_2044", 2044, 120, 0, 12'h123);
        for (int h = 0; h <= 6; h++) chk_px($sformatf("clip_wrap%0d", h), h, 120, 0, 12'h123);

        // reset mid-frame: outputs clear next edge, objects absent until next strobe
        place(20, 150, 600, 300, 400, 300, 1'b0);
        strobe();
        chk_px("pre_rst", 25, 200, 0, 12'hf00);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out, rgb_out} !== '0) begin
            errors++;
            $display("FAIL rst_mid: got rgb %h h %0d v %0d required all 0", rgb_out, hcount_out, vcount_out);
        end
        rst = 1'b0; nstrobe = 0;
        chk_px("after_rst", 25, 200, 0, 12'h123);
        strobe();
        chk_px("after_rst_strobe", 25, 200, 0, 12'hf00);

        // random stream, checked cycle by cycle by the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 150) == 0)
                place($urandom_range(0, 9) == 0 ? $urandom_range(2030, 2047) : $urandom_range(0, 300),
                      $urandom_range(0, 300), $urandom_range(0, 300), $urandom_range(0, 300),
                      $urandom_range(0, 9) == 0 ? $urandom_range(2035, 2047) : $urandom_range(0, 300),
                      $urandom_range(0, 300), 1'($urandom_range(0, 1)));
            hcount_in = 11'($urandom_range(0, 9) == 0 ? $urandom_range(2030, 2047) : $urandom_range(0, 330));
            vcount_in = 11'($urandom_range(0, 380));
            hblnk_in = ($urandom_range(0, 7) == 0);
            vblnk_in = ($urandom_range(0, 15) == 0);
            hsync_in = 1'($urandom_range(0, 1));
            vsync_in = ($urandom_range(0, 40) == 0);
            rgb_in = 12'($urandom);
            rst = ($urandom_range(0, 700) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        set_px(0, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
